// File: rtl/button_count_3bit.sv
// Two-button up/down mod-8 counter with debounce and blinking display enable;
// feeds the I/E inputs of the 3-bit 7-segment decoder.
module button_count_3bit #(
    parameter int DEB_CYCLES = 250000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UP,
    input  logic       DN,
    input  logic       CLR,
    input  logic       HOLD,
    input  logic       EN,
    input  logic       BLINK,
    output logic [2:0] I,
    output logic       E,
    output logic       CARRY,
    output logic       BORROW
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [1:0] w_raw;
    logic [1:0] w_press;

    assign w_raw = {DN, UP};

    // Per button: 2-flop synchronizer, debounce filter, rising-edge detect.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic             r_sync1;
        logic             r_sync2;
        logic             r_deb;
        logic             r_deb_d;
        logic [DEB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == DEB_LAST) begin
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
            end
        end

        assign w_press[g] = r_deb & ~r_deb_d;
    end

    logic       w_up;
    logic       w_dn;
    logic [2:0] r_i;
    logic       r_carry;
    logic       r_borrow;

    assign w_up = w_press[0];
    assign w_dn = w_press[1];

    // Clear beats hold beats presses; simultaneous presses cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i      <= 3'd0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            if (CLR) begin
                r_i <= 3'd0;
            end else if (HOLD || (w_up && w_dn)) begin
                r_i <= r_i;
            end else if (w_up) begin
                r_i     <= r_i + 3'd1;
                r_carry <= (r_i == 3'd7);
            end else if (w_dn) begin
                r_i      <= r_i - 3'd1;
                r_borrow <= (r_i == 3'd0);
            end
        end
    end

    logic [BLK_W-1:0] r_presc;
    logic             r_phase;
    logic [BLK_W-1:0] w_presc_nxt;
    logic             w_phase_nxt;
    logic             r_e;

    always_comb begin
        w_presc_nxt = '0;
        w_phase_nxt = 1'b1;
        if (BLINK) begin
            if (r_presc == BLK_LAST) begin
                w_presc_nxt = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_presc_nxt = r_presc + BLK_W'(1);
                w_phase_nxt = r_phase;
            end
        end
    end

    // E uses the next phase so it changes on the same edge as the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_phase <= 1'b1;
            r_e     <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_phase <= w_phase_nxt;
            r_e     <= EN & w_phase_nxt;
        end
    end

    assign I      = r_i;
    assign E      = r_e;
    assign CARRY  = r_carry;
    assign BORROW = r_borrow;

endmodule

// File: tb/tb_button_count_3bit.sv
// Bench for button_count_3bit: scoreboard of expected count/pulse events plus
// direct latency, priority and blink checks.
module tb_button_count_3bit;

    localparam int DEB  = 4;
    localparam int BDIV = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       UP = 1'b1;
    logic       DN = 1'b0;
    logic       CLR = 1'b0;
    logic       HOLD = 1'b0;
    logic       EN = 1'b0;
    logic       BLINK = 1'b0;
    logic [2:0] I;
    logic       E;
    logic       CARRY;
    logic       BORROW;

    typedef struct packed {
        logic [2:0] i;
        logic       c;
        logic       b;
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] prev_i = 3'd0;
    logic [2:0] m_i = 3'd0;

    button_count_3bit #(.DEB_CYCLES(DEB), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst_n(rst_n), .UP(UP), .DN(DN), .CLR(CLR), .HOLD(HOLD),
        .EN(EN), .BLINK(BLINK), .I(I), .E(E), .CARRY(CARRY), .BORROW(BORROW)
    );

    always #5 clk = ~clk;

    // Advance one edge; any count change or pulse must match the next queued event.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        if (I !== prev_i || CARRY !== 1'b0 || BORROW !== 1'b0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got I=%0d C=%b B=%b, required no event (I=%0d)",
                         I, CARRY, BORROW, prev_i);
            end else begin
                e = exp_q.pop_front();
                if ({I, CARRY, BORROW} !== {e.i, e.c, e.b}) begin
                    n_err++;
                    $display("FAIL sb_event: got I=%0d C=%b B=%b, required I=%0d C=%b B=%b",
                             I, CARRY, BORROW, e.i, e.c, e.b);
                end
            end
        end
        prev_i = I;
    endtask

    task automatic model_press(input bit up, input bit dn);
        ev_t e;
        if (up && !dn) begin
            e.i = m_i + 3'd1; e.c = (m_i == 3'd7); e.b = 1'b0;
            exp_q.push_back(e);
            m_i = e.i;
        end else if (dn && !up) begin
            e.i = m_i - 3'd1; e.c = 1'b0; e.b = (m_i == 3'd0);
            exp_q.push_back(e);
            m_i = e.i;
        end
    endtask

    task automatic model_clear();
        ev_t e;
        if (m_i != 3'd0) begin
            e.i = 3'd0; e.c = 1'b0; e.b = 1'b0;
            exp_q.push_back(e);
        end
        m_i = 3'd0;
    endtask

    task automatic press(input bit up, input bit dn, input bit hold);
        if (!hold) model_press(up, dn);
        HOLD = hold;
        UP = up;
        DN = dn;
        repeat (12) tick();
        UP = 1'b0;
        DN = 1'b0;
        repeat (12) tick();
        HOLD = 1'b0;
    endtask

    task automatic drain(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        UP = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({I, E, CARRY, BORROW} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_state: got I=%0d E=%b C=%b B=%b, required all 0", I, E, CARRY, BORROW);
        end
        rst_n = 1'b1;
        model_press(1'b1, 1'b0);
        repeat (6) tick();
        n_vec++;
        if (I !== 3'd0) begin
            n_err++;
            $display("FAIL reset_early: got I=%0d at edge 6, required 0", I);
        end
        tick();
        n_vec++;
        if (I !== 3'd1) begin
            n_err++;
            $display("FAIL reset_latency: got I=%0d at edge 7, required 1", I);
        end
        repeat (50) tick();
        UP = 1'b0;
        repeat (12) tick();
        drain("reset");
    endtask

    task automatic test_glitch();
        model_clear();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        repeat (5) begin
            UP = 1'b1;
            repeat (3) tick();
            UP = 1'b0;
            repeat (6) tick();
        end
        drain("glitch");
        n_vec++;
        if (I !== 3'd0) begin
            n_err++;
            $display("FAIL glitch_count: got I=%0d, required 0", I);
        end
    endtask

    task automatic test_wrap();
        repeat (8) press(1'b1, 1'b0, 1'b0);
        drain("wrap");
        n_vec++;
        if (I !== 3'd0) begin
            n_err++;
            $display("FAIL wrap_final: got I=%0d, required 0", I);
        end
    endtask

    task automatic test_borrow_both();
        press(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (I !== 3'd7) begin
            n_err++;
            $display("FAIL borrow_count: got I=%0d, required 7", I);
        end
        press(1'b1, 1'b1, 1'b0);
        n_vec++;
        if (I !== 3'd7) begin
            n_err++;
            $display("FAIL both_count: got I=%0d, required 7", I);
        end
        drain("borrow_both");
    endtask

    task automatic test_hold_clr();
        press(1'b1, 1'b0, 1'b1);
        repeat (6) tick();
        n_vec++;
        if (I !== 3'd7) begin
            n_err++;
            $display("FAIL hold_count: got I=%0d, required 7", I);
        end
        model_clear();
        UP = 1'b1;
        repeat (6) tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        n_vec++;
        if (I !== 3'd0 || CARRY !== 1'b0) begin
            n_err++;
            $display("FAIL clr_priority: got I=%0d C=%b, required I=0 C=0", I, CARRY);
        end
        repeat (6) tick();
        UP = 1'b0;
        repeat (12) tick();
        drain("hold_clr");
    endtask

    task automatic test_blink();
        bit ph;
        int cnt;
        EN = 1'b1;
        BLINK = 1'b0;
        n_vec++;
        if (E !== 1'b0) begin
            n_err++;
            $display("FAIL en_lag: got E=%b before edge, required 0", E);
        end
        tick();
        n_vec++;
        if (E !== 1'b1) begin
            n_err++;
            $display("FAIL en_on: got E=%b, required 1", E);
        end
        BLINK = 1'b1;
        ph = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (cnt == BDIV - 1) begin cnt = 0; ph = ~ph; end else cnt++;
            n_vec++;
            if (E !== ph) begin
                n_err++;
                $display("FAIL blink_run edge %0d: got E=%b, required %b", k, E, ph);
            end
        end
        BLINK = 1'b0;
        tick();
        n_vec++;
        if (E !== 1'b1) begin
            n_err++;
            $display("FAIL blink_stop: got E=%b, required 1", E);
        end
        BLINK = 1'b1;
        ph = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (cnt == BDIV - 1) begin cnt = 0; ph = ~ph; end else cnt++;
            n_vec++;
            if (E !== ph) begin
                n_err++;
                $display("FAIL blink_restart edge %0d: got E=%b, required %b", k, E, ph);
            end
        end
        EN = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if (E !== 1'b0) begin
                n_err++;
                $display("FAIL en_off edge %0d: got E=%b, required 0", k, E);
            end
        end
        BLINK = 1'b0;
        drain("blink");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_wrap();
        test_borrow_both();
        test_hold_clr();
        test_blink();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
